// File: rtl/addr_pair_pkg.sv
// Shared types and helpers for the lane-interleaved address sequencer.
// Sequencer states and the {idx, lane} address helper.
package addr_pair_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widths are generic; callers truncate the 32-bit result to ADDR_W.
  function automatic logic [31:0] lane_addr(
    input logic [31:0] idx,
    input logic [31:0] lane,
    input int          lane_bits
  );
    return (idx << lane_bits) | lane;
  endfunction

endpackage

// File: rtl/addr_lane_pack.sv
// Packs one {idx, lane} address per lane into a flat bus.
// Purely combinational; lane k occupies addr[k*ADDR_W +: ADDR_W].
module addr_lane_pack
  import addr_pair_pkg::*;
#(
  parameter  int ADDR_W    = 14,
  parameter  int LANE_BITS = 1,
  localparam int LANES     = 2 ** LANE_BITS,
  localparam int IDX_W     = ADDR_W - LANE_BITS
) (
  input  logic [IDX_W-1:0]        idx,
  output logic [LANES*ADDR_W-1:0] addr
);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign addr[k*ADDR_W +: ADDR_W] =
      ADDR_W'(lane_addr(32'(idx), 32'(k), LANE_BITS));
  end

endmodule

// File: rtl/addr_pair_seq.sv
// Lane-interleaved address sequencer over an inclusive index range.
// Optional beat counter output: define ADDR_PAIR_BEAT_COUNT_EN.
module addr_pair_seq
  import addr_pair_pkg::*;
#(
  parameter  int ADDR_W    = 14,
  parameter  int LANE_BITS = 1,
  localparam int LANES     = 2 ** LANE_BITS,
  localparam int IDX_W     = ADDR_W - LANE_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [IDX_W-1:0]        base_idx,
  input  logic [IDX_W-1:0]        last_idx,
  input  logic                    loop_mode,
  input  logic                    advance,
  input  logic                    abort,
  output logic                    valid,
  output logic                    busy,
  output logic                    done,
  output logic [IDX_W-1:0]        idx,
`ifdef ADDR_PAIR_BEAT_COUNT_EN
  output logic [IDX_W:0]          beat_cnt,
`endif
  output logic [LANES*ADDR_W-1:0] addr
);

  state_t           state;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] base_q;
  logic [IDX_W-1:0] last_q;
  logic             loop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idx_q  <= '0;
      base_q <= '0;
      last_q <= '0;
      loop_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (base_idx <= last_idx) begin
              base_q <= base_idx;
              last_q <= last_idx;
              loop_q <= loop_mode;
              idx_q  <= base_idx;
              state  <= RUN;
            end else begin
              state  <= DONE;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (advance) begin
            // Compare before incrementing so last = all-ones never wraps.
            if (idx_q != last_q) begin
              idx_q <= idx_q + IDX_W'(1);
            end else if (loop_q) begin
              idx_q <= base_q;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADDR_PAIR_BEAT_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
    end else if (state == IDLE && start) begin
      beat_cnt <= '0;
    end else if (state == RUN && advance && !abort) begin
      if (beat_cnt != '1) beat_cnt <= beat_cnt + (IDX_W+1)'(1);
    end
  end
`endif

  assign valid = (state == RUN);
  assign done  = (state == DONE);
  assign busy  = (state != IDLE);
  assign idx   = idx_q;

  addr_lane_pack #(
    .ADDR_W    (ADDR_W),
    .LANE_BITS (LANE_BITS)
  ) u_pack (
    .idx  (idx_q),
    .addr (addr)
  );

endmodule
